// File: rtl/dma_buffer_sequencer_pkg.sv
// ============================================================================
// Module   : dma_buffer_sequencer_pkg
// Brief    : Shared constants and state encoding for the host-DMA ring sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dma_buffer_sequencer_pkg;

  localparam int CMD_DMA_EN_BIT = 23;
  localparam int TLP_WORDS      = 32;

  typedef enum logic [1:0] {
    DSEQ_IDLE      = 2'd0,
    DSEQ_WAIT_DATA = 2'd1,
    DSEQ_REQ       = 2'd2,
    DSEQ_WAIT_DONE = 2'd3
  } dseq_state_t;

endpackage

`default_nettype wire

// File: rtl/dma_buffer_sequencer_if.sv
// ============================================================================
// Module   : dma_buffer_sequencer_if
// Brief    : Request/ack/done handshake between the sequencer and TLP engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dma_buffer_sequencer_if;

  logic        tlp_req;
  logic [24:0] tlp_offset;
  logic        tlp_ack;
  logic        tlp_done;

  modport master (
    output tlp_req,
    output tlp_offset,
    input  tlp_ack,
    input  tlp_done
  );

  modport slave (
    input  tlp_req,
    input  tlp_offset,
    output tlp_ack,
    output tlp_done
  );

endinterface

`default_nettype wire

// File: rtl/dma_buffer_sequencer.sv
// ============================================================================
// Module   : dma_buffer_sequencer
// Brief    : Host-DMA ring sequencer: one 128-byte TLP request per FIFO payload,
//            advances the buffer ring and pulses an irq per full buffer.
//            Optional WAIT_DONE watchdog enabled by defining DMA_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dma_buffer_sequencer
  import dma_buffer_sequencer_pkg::*;
#(
  parameter int N_BUFS         = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  wire logic                   trn_clk,
  input  wire logic                   pio_reset,
  input  wire logic [31:0]            command,
  input  wire logic [24:0]            dma_size,
  input  wire logic [15:0]            fifo_words,
  input  wire logic                   fifo_full,
  dma_buffer_sequencer_if.master      tlp,
  output logic      [3:0]             dma_curr_buf,
  output logic                        dma_irq,
  output logic      [31:0]            buf_count,
  output logic                        dma_overrun,
  output logic                        dma_timeout
);

  localparam logic [3:0]  c_buf_mask  = 4'(N_BUFS - 1);
  localparam logic [15:0] c_tlp_words = 16'(TLP_WORDS);

  dseq_state_t r_state;
  logic        r_en_d;
  logic [24:0] r_size;
  logic [24:0] r_offset;
  logic        r_tlp_req;
  logic [3:0]  r_curr_buf;
  logic        r_irq;
  logic [31:0] r_buf_count;
  logic        r_overrun;

  logic        w_en;
  logic        w_start;
  logic        w_last_tlp;
  logic        w_unused_cmd;

  assign w_en         = command[CMD_DMA_EN_BIT];
  assign w_unused_cmd = ^{command[31:CMD_DMA_EN_BIT+1], command[CMD_DMA_EN_BIT-1:0]};
  // Only a fresh enable edge seen while idle starts a run; a zero size is ignored.
  assign w_start      = (r_state == DSEQ_IDLE) && w_en && !r_en_d && (dma_size != 25'd0);
  assign w_last_tlp   = (r_offset + 25'd1) == r_size;

`ifdef DMA_SEQ_TIMEOUT_EN
  localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_to_cnt;
  logic        r_timeout;
  assign dma_timeout = r_timeout;
`else
  assign dma_timeout = 1'b0;
`endif

  always_ff @(posedge trn_clk or posedge pio_reset) begin
    if (pio_reset) begin
      r_state     <= DSEQ_IDLE;
      r_en_d      <= 1'b0;
      r_size      <= 25'd0;
      r_offset    <= 25'd0;
      r_tlp_req   <= 1'b0;
      r_curr_buf  <= 4'd0;
      r_irq       <= 1'b0;
      r_buf_count <= 32'd0;
      r_overrun   <= 1'b0;
`ifdef DMA_SEQ_TIMEOUT_EN
      r_to_cnt    <= 16'd0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_en_d <= w_en;
      r_irq  <= 1'b0;

      if (w_start) begin
        r_overrun <= 1'b0;
      end else if (fifo_full && w_en) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        DSEQ_IDLE: begin
          if (w_start) begin
            r_size      <= dma_size;
            r_offset    <= 25'd0;
            r_curr_buf  <= 4'd0;
            r_buf_count <= 32'd0;
`ifdef DMA_SEQ_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
            r_state     <= DSEQ_WAIT_DATA;
          end
        end

        DSEQ_WAIT_DATA: begin
          if (!w_en) begin
            r_state <= DSEQ_IDLE;
          end else if (fifo_words >= c_tlp_words) begin
            r_tlp_req <= 1'b1;
            r_state   <= DSEQ_REQ;
          end
        end

        // A dropped enable does not abort an outstanding request.
        DSEQ_REQ: begin
          if (tlp.tlp_ack) begin
            r_tlp_req <= 1'b0;
`ifdef DMA_SEQ_TIMEOUT_EN
            r_to_cnt  <= 16'd0;
`endif
            r_state   <= DSEQ_WAIT_DONE;
          end
        end

        DSEQ_WAIT_DONE: begin
          if (tlp.tlp_done) begin
            if (w_last_tlp) begin
              r_offset    <= 25'd0;
              r_curr_buf  <= (r_curr_buf + 4'd1) & c_buf_mask;
              r_buf_count <= r_buf_count + 32'd1;
              r_irq       <= 1'b1;
            end else begin
              r_offset <= r_offset + 25'd1;
            end
            r_state <= w_en ? DSEQ_WAIT_DATA : DSEQ_IDLE;
          end
`ifdef DMA_SEQ_TIMEOUT_EN
          else if (r_to_cnt == c_to_last) begin
            r_timeout <= 1'b1;
            r_tlp_req <= 1'b0;
            r_state   <= DSEQ_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
`endif
        end

        default: begin
          r_state <= DSEQ_IDLE;
        end
      endcase
    end
  end

  assign tlp.tlp_req    = r_tlp_req;
  assign tlp.tlp_offset = r_offset;
  assign dma_curr_buf   = r_curr_buf;
  assign dma_irq        = r_irq;
  assign buf_count      = r_buf_count;
  assign dma_overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_dma_buffer_sequencer.sv
// ============================================================================
// Module   : tb_dma_buffer_sequencer
// Brief    : Directed self-checking bench for dma_buffer_sequencer (N_BUFS=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dma_buffer_sequencer;
  import dma_buffer_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        pio_reset = 1'b0;
  logic [31:0] command = 32'd0;
  logic [24:0] dma_size = 25'd2;
  logic [15:0] fifo_words = 16'd64;
  logic        fifo_full = 1'b0;
  logic [3:0]  dma_curr_buf;
  logic        dma_irq;
  logic [31:0] buf_count;
  logic        dma_overrun;
  logic        dma_timeout;

  dma_buffer_sequencer_if tlp_if();

  dma_buffer_sequencer #(
    .N_BUFS         (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .trn_clk      (clk),
    .pio_reset    (pio_reset),
    .command      (command),
    .dma_size     (dma_size),
    .fifo_words   (fifo_words),
    .fifo_full    (fifo_full),
    .tlp          (tlp_if),
    .dma_curr_buf (dma_curr_buf),
    .dma_irq      (dma_irq),
    .buf_count    (buf_count),
    .dma_overrun  (dma_overrun),
    .dma_timeout  (dma_timeout)
  );

  always #5 clk = ~clk;

  // Transaction-level model: everything follows from the count of completed TLPs.
  int   m_k = 0;
  int   m_size = 1;
  logic m_ovr = 1'b0;
  logic m_irq = 1'b0;
  logic m_start = 1'b0;
  logic m_count = 1'b0;

  always @(posedge clk or posedge pio_reset) begin
    if (pio_reset) begin
      m_k    <= 0;
      m_size <= 1;
      m_ovr  <= 1'b0;
      m_irq  <= 1'b0;
    end else begin
      m_irq <= 1'b0;
      if (m_start) begin
        m_k    <= 0;
        m_size <= int'(dma_size);
        m_ovr  <= 1'b0;
      end else begin
        if (fifo_full && command[CMD_DMA_EN_BIT]) m_ovr <= 1'b1;
        if (m_count) begin
          m_k   <= m_k + 1;
          m_irq <= ((m_k + 1) % m_size) == 0;
        end
      end
    end
  end

  int total = 0;
  int bad = 0;
  int irq_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model at the falling edge, return 1ns after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (dma_irq === 1'b1) irq_cnt++;
    chk("m_offset",  32'(tlp_if.tlp_offset), 32'(m_k % m_size));
    chk("m_currbuf", 32'(dma_curr_buf),      32'((m_k / m_size) % 4));
    chk("m_bufcnt",  buf_count,              32'(m_k / m_size));
    chk("m_irq",     32'(dma_irq),           32'(m_irq));
    chk("m_overrun", 32'(dma_overrun),       32'(m_ovr));
`ifndef DMA_SEQ_TIMEOUT_EN
    chk("m_timeout", 32'(dma_timeout),       32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (tlp_if.tlp_req !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    chk("req_wait", 32'(tlp_if.tlp_req), 32'd1);
  endtask

  task automatic do_tlp(input logic [24:0] exp_off, input logic [15:0] next_words);
    wait_req();
    chk("req_offset", 32'(tlp_if.tlp_offset), 32'(exp_off));
    tlp_if.tlp_ack = 1'b1;
    cyc();
    tlp_if.tlp_ack = 1'b0;
    chk("req_drop", 32'(tlp_if.tlp_req), 32'd0);
    tlp_if.tlp_done = 1'b1;
    m_count = 1'b1;
    fifo_words = next_words;
    cyc();
    tlp_if.tlp_done = 1'b0;
    m_count = 1'b0;
  endtask

  task automatic start_run();
    command[CMD_DMA_EN_BIT] = 1'b1;
    m_start = 1'b1;
    cyc();
    m_start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int seq[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    int cnt;
    tlp_if.tlp_ack  = 1'b0;
    tlp_if.tlp_done = 1'b0;

    #1 pio_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 pio_reset = 1'b0;
    chk("rst_req",     32'(tlp_if.tlp_req),    32'd0);
    chk("rst_offset",  32'(tlp_if.tlp_offset), 32'd0);
    chk("rst_currbuf", 32'(dma_curr_buf),      32'd0);
    chk("rst_irq",     32'(dma_irq),           32'd0);
    chk("rst_bufcnt",  buf_count,              32'd0);
    chk("rst_overrun", 32'(dma_overrun),       32'd0);
    chk("rst_timeout", 32'(dma_timeout),       32'd0);

    // Start latency: request visible two edges after the enable edge.
    start_run();
    chk("req_at_N",  32'(tlp_if.tlp_req), 32'd0);
    cyc();
    chk("req_at_N1", 32'(tlp_if.tlp_req), 32'd1);

    // Nine buffers of two TLPs each around a ring of four.
    for (int b = 0; b < 9; b++) begin
      do_tlp(25'd0, 16'd64);
      do_tlp(25'd1, (b == 8) ? 16'd31 : 16'd64);
      chk("ring_irq",     32'(dma_irq),      32'd1);
      chk("ring_currbuf", 32'(dma_curr_buf), 32'(seq[b]));
      chk("ring_bufcnt",  buf_count,         32'(b + 1));
    end

    // 31 words never triggers a request; 32 does on the very next edge.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (tlp_if.tlp_req !== 1'b0) cnt++;
    end
    chk("irq_total", 32'(irq_cnt), 32'd9);
    chk("no_req_31", 32'(cnt), 32'd0);
    fifo_words = 16'd32;
    cyc();
    chk("req_at_32", 32'(tlp_if.tlp_req), 32'd1);
    do_tlp(25'd0, 16'd32);

    // Disable during REQ: the request still completes, then the block idles.
    wait_req();
    command[CMD_DMA_EN_BIT] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (tlp_if.tlp_req !== 1'b1) cnt++;
    end
    chk("req_hold_en_off", 32'(cnt), 32'd0);
    do_tlp(25'd1, 16'd64);
    chk("off_currbuf", 32'(dma_curr_buf), 32'd2);
    chk("off_bufcnt",  buf_count,         32'd10);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (tlp_if.tlp_req !== 1'b0) cnt++;
    end
    chk("idle_no_req", 32'(cnt), 32'd0);

    // Stray handshakes in IDLE change nothing.
    tlp_if.tlp_ack  = 1'b1;
    tlp_if.tlp_done = 1'b1;
    cyc();
    tlp_if.tlp_ack  = 1'b0;
    tlp_if.tlp_done = 1'b0;
    chk("stray_bufcnt", buf_count, 32'd10);

    // Enable with a zero size does not start, nor does a later size write.
    dma_size = 25'd0;
    command[CMD_DMA_EN_BIT] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tlp_if.tlp_req !== 1'b0) cnt++;
    end
    dma_size = 25'd3;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tlp_if.tlp_req !== 1'b0) cnt++;
    end
    chk("size0_no_req",  32'(cnt), 32'd0);
    chk("size0_currbuf", 32'(dma_curr_buf), 32'd2);

    // Re-enable restarts the ring; a size write mid-run is ignored.
    command[CMD_DMA_EN_BIT] = 1'b0;
    cyc();
    start_run();
    chk("restart_currbuf", 32'(dma_curr_buf), 32'd0);
    chk("restart_bufcnt",  buf_count,         32'd0);
    dma_size = 25'd1;
    do_tlp(25'd0, 16'd64);
    do_tlp(25'd1, 16'd64);
    do_tlp(25'd2, 16'd64);
    chk("size3_irq",     32'(dma_irq),      32'd1);
    chk("size3_currbuf", 32'(dma_curr_buf), 32'd1);

    // Overrun is sticky across the idle period and cleared by the next start.
    fifo_full = 1'b1;
    cyc();
    fifo_full = 1'b0;
    chk("ovr_set", 32'(dma_overrun), 32'd1);
    command[CMD_DMA_EN_BIT] = 1'b0;
    do_tlp(25'd0, 16'd64);
    repeat (5) cyc();
    chk("ovr_held", 32'(dma_overrun), 32'd1);
    start_run();
    chk("ovr_cleared", 32'(dma_overrun), 32'd0);

    // Reset in WAIT_DONE (size now 1: every TLP closes a buffer).
    do_tlp(25'd0, 16'd64);
    do_tlp(25'd0, 16'd64);
    chk("pre_rst_currbuf", 32'(dma_curr_buf), 32'd2);
    wait_req();
    tlp_if.tlp_ack = 1'b1;
    cyc();
    tlp_if.tlp_ack = 1'b0;
    pio_reset = 1'b1;
    command = 32'd0;
    #1;
    chk("mid_rst_currbuf", 32'(dma_curr_buf), 32'd0);
    chk("mid_rst_bufcnt",  buf_count,         32'd0);
    chk("mid_rst_req",     32'(tlp_if.tlp_req), 32'd0);
    cyc();
    pio_reset = 1'b0;
    cyc();
    chk("post_rst_currbuf", 32'(dma_curr_buf), 32'd0);
    chk("post_rst_req",     32'(tlp_if.tlp_req), 32'd0);

    // Withheld tlp_done.
    start_run();
    wait_req();
    tlp_if.tlp_ack = 1'b1;
    cyc();
    tlp_if.tlp_ack = 1'b0;
`ifdef DMA_SEQ_TIMEOUT_EN
    repeat (99) cyc();
    chk("to_before", 32'(dma_timeout), 32'd0);
    cyc();
    chk("to_at_100", 32'(dma_timeout), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tlp_if.tlp_req !== 1'b0) cnt++;
    end
    chk("to_idle_no_req", 32'(cnt), 32'd0);
    tlp_if.tlp_done = 1'b1;
    cyc();
    tlp_if.tlp_done = 1'b0;
    chk("to_late_done", buf_count, 32'd0);
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (tlp_if.tlp_req !== 1'b0 || dma_timeout !== 1'b0) cnt++;
    end
    chk("wait_forever", 32'(cnt), 32'd0);
    tlp_if.tlp_done = 1'b1;
    m_count = 1'b1;
    cyc();
    tlp_if.tlp_done = 1'b0;
    m_count = 1'b0;
    chk("late_done_irq",     32'(dma_irq),      32'd1);
    chk("late_done_currbuf", 32'(dma_curr_buf), 32'd1);
    chk("late_done_bufcnt",  buf_count,         32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
